// File: rtl/keypad_scanner_if.sv
// Key-event bundle from the keypad scanner to its consumer (display mux, CPU).
//   key_valid : one-cycle pulse per accepted key press
//   key_code  : hex code of the last accepted key
//   key_held  : high from acceptance until the release is debounced
//   digits    : [7:4] previous key, [3:0] most recent key
// master = scanner (drives), slave = consumer (reads).
interface keypad_scanner_if;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_held;
    logic [7:0] digits;

    modport master (output key_valid, output key_code, output key_held, output digits);
    modport slave  (input  key_valid, input  key_code, input  key_held, input  digits);
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: drives one active-low column at a time, reads the
// active-low rows through a 2-flop synchronizer, debounces press and release,
// decodes the key to a hex nibble and shifts it into a two-digit register.
//   clk   : system clock
//   reset : synchronous, active-high
//   rows  : keypad rows, active-low, asynchronous to clk
//   cols  : keypad columns, active-low one-hot
//   kp    : key event outputs (key_valid, key_code, key_held, digits)
module keypad_scanner #(
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned SCAN_DIV        = 5000,
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        rows,
    output logic [3:0]        cols,
    keypad_scanner_if.master  kp
);

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_e           state_q, state_d;
    logic [3:0]       cols_q, cols_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       sync1_q, rs_q;
    logic [1:0]       r_idx_q, r_idx_d;
    logic [1:0]       c_idx_q, c_idx_d;
    logic [3:0]       pat_q, pat_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_held_q, key_held_d;
    logic [7:0]       digits_q, digits_d;

    logic [3:0]       cols_next;
    logic [3:0]       code;

    // Row r / column c to hex legend of the keypad.
    function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        case ({r, c})
            4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
            4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
            4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
            4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
        endcase
        return k;
    endfunction

    // Index of the lowest zero bit; lowest row wins when several are low.
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        logic [1:0] i;
        if (!v[0])      i = 2'd0;
        else if (!v[1]) i = 2'd1;
        else if (!v[2]) i = 2'd2;
        else            i = 2'd3;
        return i;
    endfunction

    assign cols_next = {cols_q[2:0], cols_q[3]};
    assign code      = key_map(r_idx_q, c_idx_q);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_SCAN;
            cols_q      <= 4'b1110;
            cnt_q       <= '0;
            sync1_q     <= '1;
            rs_q        <= '1;
            r_idx_q     <= '0;
            c_idx_q     <= '0;
            pat_q       <= '1;
            key_valid_q <= 1'b0;
            key_code_q  <= '0;
            key_held_q  <= 1'b0;
            digits_q    <= '0;
        end else begin
            state_q     <= state_d;
            cols_q      <= cols_d;
            cnt_q       <= cnt_d;
            sync1_q     <= rows;
            rs_q        <= sync1_q;
            r_idx_q     <= r_idx_d;
            c_idx_q     <= c_idx_d;
            pat_q       <= pat_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
            digits_q    <= digits_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cols_d      = cols_q;
        cnt_d       = cnt_q;
        r_idx_d     = r_idx_q;
        c_idx_d     = c_idx_q;
        pat_d       = pat_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        digits_d    = digits_q;

        case (state_q)
            ST_SCAN: begin
                if (cnt_q == SCAN_LAST) begin
                    cnt_d = '0;
                    if (rs_q == 4'hF) begin
                        cols_d = cols_next;
                    end else begin
                        r_idx_d = low_idx(rs_q);
                        c_idx_d = low_idx(cols_q);
                        pat_d   = rs_q;
                        state_d = ST_DEBOUNCE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DEBOUNCE: begin
                if (rs_q != pat_q) begin
                    cnt_d   = '0;
                    cols_d  = cols_next;
                    state_d = ST_SCAN;
                end else if (cnt_q == DB_LAST) begin
                    // Outputs are registered on entry so they are visible
                    // during the single PRESSED cycle.
                    cnt_d       = '0;
                    state_d     = ST_PRESSED;
                    key_valid_d = 1'b1;
                    key_code_d  = code;
                    digits_d    = {digits_q[3:0], code};
                    key_held_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_PRESSED: begin
                state_d = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (rs_q != 4'hF) begin
                    cnt_d = '0;
                end else if (cnt_q == DB_LAST) begin
                    cnt_d      = '0;
                    key_held_d = 1'b0;
                    cols_d     = cols_next;
                    state_d    = ST_SCAN;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d    = ST_SCAN;
                cols_d     = 4'b1110;
                cnt_d      = '0;
                key_held_d = 1'b0;
            end
        endcase
    end

    assign cols         = cols_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_held  = key_held_q;
    assign kp.digits    = digits_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner with SCAN_DIV=4, DEBOUNCE_CYCLES=8. A keypad model
// pulls row r low while column c is driven for every pressed key; an extra
// glitch vector forces rows low directly. Accepted-key events are queued by a
// monitor and compared against expectations queued when keys are pressed.
module tb_keypad_scanner;

    logic        clk;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [15:0] press;   // bit r*4+c
    logic [3:0]  glitch;  // forces rows low

    keypad_scanner_if kif ();

    keypad_scanner #(
        .CNT_W           (20),
        .SCAN_DIV        (4),
        .DEBOUNCE_CYCLES (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rows  (rows),
        .cols  (cols),
        .kp    (kif.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        rows = 4'hF;
        for (int unsigned r = 0; r < 4; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                if (press[r*4+c] && !cols[c]) rows[r] = 1'b0;
            end
        end
        rows = rows & ~glitch;
    end

    int unsigned n_cmp;
    int unsigned n_bad;
    logic [12:0] exp_q[$];  // {key_held, key_code, digits}
    logic [12:0] obs_q[$];
    logic [7:0]  exp_digits;

    always @(negedge clk) begin
        if (!reset && kif.key_valid)
            obs_q.push_back({kif.key_held, kif.key_code, kif.digits});
    end

    task automatic expect_key(input logic [3:0] k);
        exp_digits = {exp_digits[3:0], k};
        exp_q.push_back({1'b1, k, exp_digits});
    endtask

    task automatic wait_valid(input int unsigned max, output bit seen);
        seen = 1'b0;
        for (int unsigned i = 0; i < max; i++) begin
            @(posedge clk); #1;
            if (kif.key_valid) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_held_low(input int unsigned max, output bit seen);
        seen = 1'b0;
        for (int unsigned i = 0; i < max; i++) begin
            @(posedge clk); #1;
            if (!kif.key_held) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_cols;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        exp_cols = 4'b1110;
        n_cmp++; if (cols !== 4'b1110) begin n_bad++; $display("FAIL reset_cols got=%b exp=1110", cols); end
        n_cmp++; if (kif.key_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got=%b exp=0", kif.key_valid); end
        n_cmp++; if (kif.key_held !== 1'b0) begin n_bad++; $display("FAIL reset_held got=%b exp=0", kif.key_held); end
        n_cmp++; if (kif.key_code !== 4'h0) begin n_bad++; $display("FAIL reset_code got=%h exp=0", kif.key_code); end
        n_cmp++; if (kif.digits !== 8'h00) begin n_bad++; $display("FAIL reset_digits got=%h exp=00", kif.digits); end
        for (int unsigned i = 1; i < 20; i++) begin
            @(posedge clk); #1;
            if (i % 4 == 0) exp_cols = {exp_cols[2:0], exp_cols[3]};
            n_cmp++; if (cols !== exp_cols) begin n_bad++; $display("FAIL idle_cols[%0d] got=%b exp=%b", i, cols, exp_cols); end
            n_cmp++; if (kif.key_valid !== 1'b0) begin n_bad++; $display("FAIL idle_valid[%0d] got=%b exp=0", i, kif.key_valid); end
        end
        n_cmp++; if (kif.digits !== 8'h00) begin n_bad++; $display("FAIL idle_digits got=%h exp=00", kif.digits); end
    endtask

    task automatic test_press_5_9();
        bit seen;
        logic [12:0] e, o;
        press[5] = 1'b1;
        expect_key(4'h5);
        wait_valid(200, seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL key5_pulse got=timeout exp=pulse"); end
        n_cmp++; if (kif.key_held !== 1'b1) begin n_bad++; $display("FAIL key5_held got=%b exp=1", kif.key_held); end
        repeat (30) @(posedge clk);
        #1;
        n_cmp++; if (kif.key_held !== 1'b1) begin n_bad++; $display("FAIL key5_held_hold got=%b exp=1", kif.key_held); end
        press[5] = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        n_cmp++; if (kif.key_held !== 1'b1) begin n_bad++; $display("FAIL key5_release_early got=%b exp=1", kif.key_held); end
        @(posedge clk); #1;
        n_cmp++; if (kif.key_held !== 1'b0) begin n_bad++; $display("FAIL key5_release got=%b exp=0", kif.key_held); end
        press[10] = 1'b1;
        expect_key(4'h9);
        wait_valid(200, seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL key9_pulse got=timeout exp=pulse"); end
        press[10] = 1'b0;
        wait_held_low(50, seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL key9_release got=timeout exp=held_low"); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL press_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL press_event got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_bounce();
        bit found;
        logic [3:0] prev;
        logic [12:0] e, o;
        found = 1'b0;
        prev = cols;
        for (int unsigned i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (prev != 4'b1110 && cols == 4'b1110) begin
                found = 1'b1;
                break;
            end
            prev = cols;
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL bounce_col0 got=timeout exp=cols_1110"); end
        press[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1 press[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (cols !== 4'b1110) begin n_bad++; $display("FAIL bounce_hold_col got=%b exp=1110", cols); end
        @(posedge clk); #1;
        n_cmp++; if (cols !== 4'b1101) begin n_bad++; $display("FAIL bounce_abort_col got=%b exp=1101", cols); end
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (kif.digits !== exp_digits) begin n_bad++; $display("FAIL bounce_digits got=%h exp=%h", kif.digits, exp_digits); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL bounce_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL bounce_event got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_glitch_release();
        bit seen;
        logic [12:0] e, o;
        press[15] = 1'b1;
        expect_key(4'hD);
        wait_valid(200, seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL keyD_pulse got=timeout exp=pulse"); end
        repeat (200) @(posedge clk);
        #1;
        n_cmp++; if (kif.key_held !== 1'b1) begin n_bad++; $display("FAIL keyD_held got=%b exp=1", kif.key_held); end
        press[15] = 1'b0;
        repeat (5) @(posedge clk);
        #1 glitch = 4'b1000;
        repeat (2) @(posedge clk);
        #1 glitch = 4'b0000;
        repeat (9) @(posedge clk);
        #1;
        n_cmp++; if (kif.key_held !== 1'b1) begin n_bad++; $display("FAIL glitch_held_early got=%b exp=1", kif.key_held); end
        @(posedge clk); #1;
        n_cmp++; if (kif.key_held !== 1'b0) begin n_bad++; $display("FAIL glitch_release got=%b exp=0", kif.key_held); end
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL glitch_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL glitch_event got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_same_column();
        bit seen;
        logic [12:0] e, o;
        press[0] = 1'b1;
        expect_key(4'h1);
        wait_valid(200, seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL key1_pulse got=timeout exp=pulse"); end
        repeat (5) @(posedge clk);
        #1 press[4] = 1'b1;
        repeat (20) @(posedge clk);
        #1 press[0] = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        n_cmp++; if (kif.key_held !== 1'b1) begin n_bad++; $display("FAIL samecol_held got=%b exp=1", kif.key_held); end
        press[4] = 1'b0;
        wait_held_low(50, seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL samecol_release got=timeout exp=held_low"); end
        press[4] = 1'b1;
        expect_key(4'h4);
        wait_valid(200, seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL key4_pulse got=timeout exp=pulse"); end
        n_cmp++; if (kif.digits !== 8'h14) begin n_bad++; $display("FAIL key4_digits got=%h exp=14", kif.digits); end
        press[4] = 1'b0;
        wait_held_low(50, seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL key4_release got=timeout exp=held_low"); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL samecol_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL samecol_event got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid_release();
        bit seen;
        logic [12:0] e, o;
        press[12] = 1'b1;
        expect_key(4'hE);
        wait_valid(200, seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL keyE_pulse got=timeout exp=pulse"); end
        repeat (10) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        n_cmp++; if (cols !== 4'b1110) begin n_bad++; $display("FAIL rst_mid_cols got=%b exp=1110", cols); end
        n_cmp++; if (kif.key_held !== 1'b0) begin n_bad++; $display("FAIL rst_mid_held got=%b exp=0", kif.key_held); end
        n_cmp++; if (kif.key_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid got=%b exp=0", kif.key_valid); end
        n_cmp++; if (kif.digits !== 8'h00) begin n_bad++; $display("FAIL rst_mid_digits got=%h exp=00", kif.digits); end
        exp_digits = 8'h00;
        expect_key(4'hE);
        wait_valid(200, seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL keyE_again_pulse got=timeout exp=pulse"); end
        press[12] = 1'b0;
        wait_held_low(50, seen);
        n_cmp++; if (!seen) begin n_bad++; $display("FAIL keyE_release got=timeout exp=held_low"); end
        n_cmp++; if (obs_q.size() != exp_q.size()) begin n_bad++; $display("FAIL rst_mid_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() != 0 && obs_q.size() != 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            n_cmp++; if (o !== e) begin n_bad++; $display("FAIL rst_mid_event got=%h exp=%h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        n_cmp      = 0;
        n_bad      = 0;
        reset      = 1'b1;
        press      = '0;
        glitch     = '0;
        exp_digits = 8'h00;
        test_reset();
        test_press_5_9();
        test_bounce();
        test_glitch_release();
        test_same_column();
        test_reset_mid_release();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=still_running exp=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
